// File: rtl/sqrt_pkg.sv
// Shared types and widths for the square-root unit and its RMS feeder.
package sqrt_pkg;

  // Feeder sequencing: gather a block, kick the root unit, wait for its answer.
  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } rms_state_t;

  localparam int SMPL_W = 8;   // signed sample width
  localparam int SQ_W   = 15;  // unsigned square of a sample, max 16384
  localparam int OP_W   = 16;  // root-unit operand width
  localparam int ROOT_W = 8;   // root-unit result width

endpackage : sqrt_pkg

// File: rtl/rms_accum.sv
// Block mean-square accumulator feeding the square-root unit, and RMS
// result collector. Sums squares of 2^L_SAMP samples, launches the root
// unit on the floor mean, and republishes the root with a one-cycle valid.
module rms_accum
  import sqrt_pkg::*;
#(
  parameter int L_SAMP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SMPL_W-1:0] smpl,
  input  logic              smpl_vld,
  output logic              busy,
  output logic              sq_go,
  output logic [OP_W-1:0]   sq_op,
  input  logic [ROOT_W-1:0] sq_result,
  input  logic              sq_done,
  input  logic              sq_err,
  output logic [ROOT_W-1:0] rms,
  output logic              rms_vld,
  output logic              rms_err,
  output logic              ovr
);

  // Accumulator is wide enough for N squares of 16384, so it never wraps.
  localparam int ACC_W = SQ_W + L_SAMP;
  // A zero-width counter is illegal, so a single-sample block still gets one bit.
  localparam int CNT_W = (L_SAMP > 0) ? L_SAMP : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << L_SAMP) - 1);

  rms_state_t        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              go_q, go_d;
  logic              busy_q, busy_d;
  logic [ROOT_W-1:0] rms_q, rms_d;
  logic              rms_vld_q, rms_vld_d;
  logic              rms_err_q, rms_err_d;
  logic              ovr_q, ovr_d;

  logic signed [2*SMPL_W-1:0] prod;
  logic [SQ_W-1:0]            sq;
  logic [ACC_W-1:0]           sum;
  logic                       accept;
  logic                       last;

  // Square of the signed sample; the result is non-negative and fits 15 bits.
  assign prod = $signed(smpl) * $signed(smpl);
  assign sq   = SQ_W'(prod);
  assign sum  = acc_q + ACC_W'(sq);

  // Samples are only taken in ACCUM; anything else while busy is an overrun.
  assign accept = smpl_vld && (state_q == ACCUM);
  assign last   = accept && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode. LAUNCH never looks at sq_done: it may still be high
  // from the previous operation until the root unit sees the new go.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (last) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (sq_done) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Datapath and output next values; every output is registered.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rms_d     = rms_q;
    rms_err_d = rms_err_q;
    rms_vld_d = 1'b0;
    go_d      = (state_d == LAUNCH);
    busy_d    = (state_d != ACCUM);
    ovr_d     = ovr_q | (smpl_vld && (state_q != ACCUM));
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            // Floor mean of the completed block, including this sample.
            cnt_d = '0;
            op_d  = {1'b0, SQ_W'(sum >> L_SAMP)};
          end
        end
      end
      LAUNCH: begin
      end
      WAIT: begin
        if (sq_done) begin
          rms_d     = sq_result;
          rms_err_d = sq_err;
          rms_vld_d = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
        end
      end
      default: begin
        acc_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      rms_q     <= '0;
      rms_vld_q <= 1'b0;
      rms_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
      rms_q     <= rms_d;
      rms_vld_q <= rms_vld_d;
      rms_err_q <= rms_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign busy    = busy_q;
  assign sq_go   = go_q;
  assign sq_op   = op_q;
  assign rms     = rms_q;
  assign rms_vld = rms_vld_q;
  assign rms_err = rms_err_q;
  assign ovr     = ovr_q;

endmodule : rms_accum

// File: doc/rms_accum.md
# rms_accum

Upstream feeder and result collector for the successive-approximation square-root unit. Accumulates the squares of a block of 2^L_SAMP signed 8-bit samples and forms their floor mean. Presents that mean as a stable operand with a one-cycle go, waits for the root's done, and republishes the root as an RMS value with a one-cycle valid. The root unit sits beside this block at the top level; this block drives its go/op and consumes its sqrt/done/err.

## Interface
- L_SAMP, 4, log2 of samples per block; legal range 0..8; block size N = 2^L_SAMP
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- smpl  input  8  signed two's-complement sample
- smpl_vld  input  1  sample qualifier, one sample per high cycle
- busy  output  1  high in LAUNCH/WAIT; samples not accepted
- sq_go  output  1  one-cycle start pulse to root unit
- sq_op  output  16  operand to root unit, registered, held stable until next launch
- sq_result  input  8  root from root unit
- sq_done  input  1  root unit done, level, stays high until its next start
- sq_err  input  1  root unit negative-operand flag
- rms  output  8  captured root
- rms_vld  output  1  one-cycle pulse, rms/rms_err valid
- rms_err  output  1  copy of sq_err at capture
- ovr  output  1  sticky: a sample arrived while busy

## Operation
- States: ACCUM, LAUNCH, WAIT. Reset → ACCUM.
- ACCUM: on smpl_vld, acc += smpl*smpl (signed multiply, 15-bit unsigned square, max 16384 for -128) and cnt++. Accumulator width is 15+L_SAMP bits, so it cannot overflow.
- When the accepted sample is the Nth (cnt == N-1): the same edge registers sq_op = {1'b0, (acc+sq)>>L_SAMP truncated to 15 bits} (floor mean, ≤16384) and moves to LAUNCH.
- LAUNCH: sq_go=1 for exactly this cycle. sq_done is ignored in this cycle, because it may still be high from the previous op. Next state is WAIT.
- WAIT: hold sq_op. When sq_done=1, the edge does all of the following: rms←sq_result, rms_err←sq_err, rms_vld←1 for one cycle, acc←0, cnt←0, state→ACCUM.
- sq_op[15] is always 0, so rms_err is expected 0. It is still propagated.
- smpl_vld while busy: the sample is dropped and ovr←1. Only rst clears ovr.
- smpl_vld in the same cycle as the WAIT→ACCUM transition: dropped (busy still high), ovr set.

## Timing
- Reset values: state ACCUM, acc 0, cnt 0, sq_op 0, sq_go 0, busy 0, rms 0, rms_vld 0, rms_err 0, ovr 0.
- Reset has priority over all other events at any point, including mid-WAIT. After reset, sq_go stays 0 until a full new block of N samples is accepted.
- Edge E0 accepts the last sample. The cycle after E0 is LAUNCH (sq_go=1). With the companion root unit:
  - the root unit enters compute at E1;
  - done rises after E9;
  - capture happens at E10;
  - rms_vld is high in the cycle after E10.
- Throughput: one result per N accepted samples plus 10 busy cycles.
- sq_op changes only at the E0-type edge and is stable from LAUNCH through capture. The root unit compares against op every cycle, so this stability is mandatory.
- busy is a registered decode of state (LAUNCH or WAIT); no combinational path from smpl_vld.

## Structure
- Shared package sqrt_pkg:
  - rms_state_t enum {ACCUM, LAUNCH, WAIT}
  - localparams SMPL_W=8, SQ_W=15, OP_W=16, ROOT_W=8
- No sub-module. The root unit is instantiated alongside this block in the top-level integration, not inside it.
- For bench use, a behavioural root-unit model with a 9-cycle done is acceptable. The integration test uses the real unit.

## Test plan
- L_SAMP=4, 16 samples of +3 → sq_op=9, one sq_go pulse, rms=3, rms_err=0, rms_vld 10 edges after last sample.
- 16 samples of -128 → sq_op=16384 (0x4000), rms=128.
- 8 samples of +10, then 8 of 0 → sq_op=50, rms=7 (floor).
- 16 samples of 5, then 3 extra samples during WAIT → extras dropped, ovr=1 and sticky, rms=5. The next block starts from acc=0.
- rst asserted in WAIT cycle 4 → all outputs at reset values next cycle, no rms_vld. A fresh 16-sample block of +2 gives rms=2.
- Bench model returns sq_err=1, sq_result=0 → rms_err=1, rms=0 with rms_vld. Also check that sq_done held high from the prior op is ignored during LAUNCH.
